// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared widths and write-back request types for the register file write-back path.
package sp_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int XLEN           = 32;
  localparam int NUM_WB_REQ     = 3;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]           data;
  } wb_req_t;

  typedef logic [$clog2(NUM_WB_REQ)-1:0] wb_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: pointer register plus one-hot grant search with wrap.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;
  logic          found;

  // Search starts at the pointer and wraps, so the most recently served requester goes last.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found                     = 1'b1;
        grant_o[cand[IW-1:0]]     = 1'b1;
        grant_idx_o               = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port among requesters; RF_WB_STATS_EN adds grant counters.
module regfile_wb_arbiter
  import sp_pkg::*;
#(
  parameter  int NUM_WB_REQ = sp_pkg::NUM_WB_REQ,
  localparam int IW         = (NUM_WB_REQ > 1) ? $clog2(NUM_WB_REQ) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_WB_REQ-1:0]                      req_valid_i,
  output logic [NUM_WB_REQ-1:0]                      req_ready_o,
  input  logic [NUM_WB_REQ-1:0][REG_ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_WB_REQ-1:0][XLEN-1:0]            req_data_i,
  input  logic                                       hold_i,
`ifdef RF_WB_STATS_EN
  output logic [NUM_WB_REQ-1:0][15:0]                grant_cnt_o,
`endif
  output logic                                       wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0]                  wr_addr_o,
  output logic [XLEN-1:0]                            wr_data_o,
  output logic [IW-1:0]                              grant_idx_o
);

  logic [NUM_WB_REQ-1:0] req_eff;
  logic [IW-1:0]         arb_idx;
  logic                  transfer;

  wb_req_t       stage_q, stage_d;
  logic          wr_en_q, wr_en_d;
  logic [IW-1:0] idx_q, idx_d;

  // Reset also masks requests so nothing is acknowledged while the stage is being cleared.
  assign req_eff  = (hold_i || rst_i) ? '0 : req_valid_i;
  assign transfer = |req_ready_o;

  rr_arbiter #(.N(NUM_WB_REQ)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_eff),
    .advance_i   (transfer),
    .grant_o     (req_ready_o),
    .grant_idx_o (arb_idx)
  );

  always_comb begin
    stage_d = stage_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    if (transfer) begin
      stage_d.addr = req_addr_i[arb_idx];
      stage_d.data = req_data_i[arb_idx];
      idx_d        = arb_idx;
      wr_en_d      = (req_addr_i[arb_idx] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = stage_q.addr;
  assign wr_data_o   = stage_q.data;
  assign grant_idx_o = idx_q;

`ifdef RF_WB_STATS_EN
  logic [NUM_WB_REQ-1:0][15:0] cnt_q;

  // Register-0 transfers count too; each counter saturates at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WB_REQ; i++) begin
        if (req_ready_o[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized checks of regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
  import sp_pkg::*;

  localparam int N = 3;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic [N-1:0]                         valid;
  logic [N-1:0]                         req_ready;
  logic [N-1:0][REG_ADDR_WIDTH-1:0]     addr;
  logic [N-1:0][XLEN-1:0]               data;
  logic                                 hold;
  logic                                 wr_en;
  logic [REG_ADDR_WIDTH-1:0]            wr_addr;
  logic [XLEN-1:0]                      wr_data;
  logic [1:0]                           grant_idx;
`ifdef RF_WB_STATS_EN
  logic [N-1:0][15:0]                   grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int                   m_ptr;
  logic                 m_en;
  logic [REG_ADDR_WIDTH-1:0] m_addr;
  logic [XLEN-1:0]      m_data;
  int                   m_idx;
  int                   m_cnt [N];
  logic [N-1:0]         last_ready;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_WB_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_ready_o (req_ready),
    .req_addr_i  (addr),
    .req_data_i  (data),
    .hold_i      (hold),
`ifdef RF_WB_STATS_EN
    .grant_cnt_o (grant_cnt),
`endif
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .grant_idx_o (grant_idx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Inputs are already driven; checks the combinational grant, advances the model, then checks the stage.
  task automatic tick();
    int w;
    logic [N-1:0] er;
    #3;
    er = '0;
    w  = -1;
    if (!rst && !hold) w = winner(valid, m_ptr);
    if (w >= 0) er[w] = 1'b1;
    check("ready", 64'(req_ready), 64'(er));
    last_ready = er;
    if (rst) begin
      m_en = 1'b0; m_addr = '0; m_data = '0; m_idx = 0; m_ptr = 0;
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
    end else if (w >= 0) begin
      m_en   = (addr[w] != 0);
      m_addr = addr[w];
      m_data = data[w];
      m_idx  = w;
      m_ptr  = (w + 1) % N;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end else begin
      m_en = 1'b0;
    end
    @(posedge clk);
    #1;
    check("wr_en", 64'(wr_en), 64'(m_en));
    check("wr_addr", 64'(wr_addr), 64'(m_addr));
    check("wr_data", 64'(wr_data), 64'(m_data));
    check("grant_idx", 64'(grant_idx), 64'(m_idx));
`ifdef RF_WB_STATS_EN
    for (int r = 0; r < N; r++) check("grant_cnt", 64'(grant_cnt[r]), 64'(m_cnt[r]));
`endif
  endtask

  task automatic set_all_valid();
    valid = '1;
    for (int r = 0; r < N; r++) begin
      addr[r] = REG_ADDR_WIDTH'(r + 1);
      data[r] = XLEN'(32'h1000 + r);
    end
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    last_ready = '0;
    set_all_valid();
    m_ptr = 0;
    for (int r = 0; r < N; r++) m_cnt[r] = 0;
    @(posedge clk);
    #1;

    tick();
    tick();
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_grant_idx", 64'(grant_idx), 64'd0);

    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_order", 64'(grant_idx), 64'(k % 3));
      check("rr_wr_en", 64'(wr_en), 64'd1);
    end

    valid = 3'b010;
    addr[1] = 5'd5;
    data[1] = 32'hDEADBEEF;
    tick();
    check("single_en", 64'(wr_en), 64'd1);
    check("single_addr", 64'(wr_addr), 64'd5);
    check("single_data", 64'(wr_data), 64'hDEADBEEF);
    valid = '0;
    tick();
    check("single_drain", 64'(wr_en), 64'd0);

    valid = 3'b100;
    addr[2] = 5'd0;
    data[2] = 32'h1234;
    tick();
    check("addr0_idx", 64'(grant_idx), 64'd2);
    check("addr0_en", 64'(wr_en), 64'd0);
    set_all_valid();
    tick();
    check("addr0_next", 64'(grant_idx), 64'd0);

    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_en", 64'(wr_en), 64'd0);
    end
    hold = 1'b0;
    tick();
    check("hold_resume", 64'(grant_idx), 64'd1);

    rst = 1'b1;
    tick();
    check("midrst_en", 64'(wr_en), 64'd0);
    rst = 1'b0;
    tick();
    check("midrst_next", 64'(grant_idx), 64'd0);

    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (last_ready[r] || !valid[r]) begin
          if ($urandom_range(1, 0) == 1) begin
            valid[r] = 1'b1;
            addr[r]  = ($urandom_range(5, 0) == 0) ? '0 : REG_ADDR_WIDTH'($urandom);
            data[r]  = $urandom;
          end else begin
            valid[r] = 1'b0;
          end
        end else if ($urandom_range(9, 0) == 0) begin
          valid[r] = 1'b0;
        end
      end
      hold = ($urandom_range(6, 0) == 0);
      rst  = ($urandom_range(49, 0) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
